// File: rtl/min_max_job_scheduler.sv
// Two-requester round-robin front end for a shared 16 x 8-bit min/max engine.
// Optional MINMAX_SCHED_STATS_EN adds saturating job/error counters.
module min_max_job_scheduler #(
   parameter int unsigned TIMEOUT_CYC = 64,
   parameter int unsigned TO_W        = 7
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic [1:0]   req_i,
   input  logic [127:0] arr0_i,
   input  logic [127:0] arr1_i,
   output logic [1:0]   gnt_o,
   output logic         mem_we_o,
   output logic [3:0]   mem_addr_o,
   output logic [7:0]   mem_wdata_o,
   output logic         eng_start_o,
   input  logic         eng_done_i,
   input  logic [7:0]   eng_max_i,
   input  logic [7:0]   eng_min_i,
   output logic         rsp_valid_o,
   output logic         rsp_id_o,
   output logic [7:0]   rsp_max_o,
   output logic [7:0]   rsp_min_o,
   output logic         rsp_err_o,
   input  logic         rsp_ack_i,
   output logic         qi_o,
   output logic         qc_o,
   output logic         qs_o,
   output logic         qw_o,
   output logic         qr_o
`ifdef MINMAX_SCHED_STATS_EN
   ,
   output logic [15:0]  job_cnt_o,
   output logic [7:0]   err_cnt_o
`endif
);

   typedef enum logic [2:0] {StIdle, StCopy, StStart, StWait, StResp} state_e;

   state_e          state_q, state_d;
   logic [127:0]    shadow_q, shadow_d;
   logic [3:0]      idx_q, idx_d;
   logic            id_q, id_d;
   logic            last_q, last_d;
   logic            armed_q, armed_d;
   logic [TO_W-1:0] to_q, to_d;
   logic [7:0]      max_q, max_d, min_q, min_d;
   logic            err_q, err_d;
   logic [1:0]      gnt_q, gnt_d;
   logic            win;
   logic            timeout;
   logic            done_ok;

   // Both requesting: the one not served last wins.
   assign win     = (req_i == 2'b11) ? ~last_q : req_i[1];
   assign timeout = (to_q == TO_W'(TIMEOUT_CYC - 1));
   assign done_ok = eng_done_i & armed_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) state_q <= StIdle;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (req_i != 2'b00) state_d = StCopy;
         StCopy:  if (idx_q == 4'd15) state_d = StStart;
         StStart: state_d = StWait;
         StWait:  if (done_ok || timeout) state_d = StResp;
         StResp:  if (rsp_ack_i) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      shadow_d = shadow_q;
      idx_d    = idx_q;
      id_d     = id_q;
      last_d   = last_q;
      armed_d  = armed_q;
      to_d     = to_q;
      max_d    = max_q;
      min_d    = min_q;
      err_d    = err_q;
      gnt_d    = 2'b00;
      unique case (state_q)
         StIdle: begin
            if (req_i != 2'b00) begin
               gnt_d    = win ? 2'b10 : 2'b01;
               shadow_d = win ? arr1_i : arr0_i;
               id_d     = win;
               idx_d    = 4'd0;
            end
         end
         StCopy:  idx_d = idx_q + 4'd1;
         StStart: begin
            to_d    = '0;
            armed_d = 1'b0;
         end
         StWait: begin
            if (!eng_done_i) armed_d = 1'b1;
            to_d = to_q + 1'b1;
            if (done_ok) begin
               max_d = eng_max_i;
               min_d = eng_min_i;
               err_d = 1'b0;
            end else if (timeout) begin
               max_d = 8'h00;
               min_d = 8'h00;
               err_d = 1'b1;
            end
         end
         StResp:  if (rsp_ack_i) last_d = id_q;
         default: ;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         shadow_q <= '0;
         idx_q    <= '0;
         id_q     <= 1'b0;
         last_q   <= 1'b1;  // requester 0 gets first priority after reset
         armed_q  <= 1'b0;
         to_q     <= '0;
         max_q    <= '0;
         min_q    <= '0;
         err_q    <= 1'b0;
         gnt_q    <= '0;
      end else begin
         shadow_q <= shadow_d;
         idx_q    <= idx_d;
         id_q     <= id_d;
         last_q   <= last_d;
         armed_q  <= armed_d;
         to_q     <= to_d;
         max_q    <= max_d;
         min_q    <= min_d;
         err_q    <= err_d;
         gnt_q    <= gnt_d;
      end
   end

   always_comb begin
      qi_o        = (state_q == StIdle);
      qc_o        = (state_q == StCopy);
      qs_o        = (state_q == StStart);
      qw_o        = (state_q == StWait);
      qr_o        = (state_q == StResp);
      gnt_o       = gnt_q;
      mem_we_o    = qc_o;
      mem_addr_o  = qc_o ? idx_q : 4'd0;
      mem_wdata_o = qc_o ? shadow_q[{idx_q, 3'b000} +: 8] : 8'h00;
      eng_start_o = qs_o;
      rsp_valid_o = qr_o;
      rsp_id_o    = id_q;
      rsp_max_o   = max_q;
      rsp_min_o   = min_q;
      rsp_err_o   = err_q;
   end

`ifdef MINMAX_SCHED_STATS_EN
   logic [15:0] job_cnt_q, job_cnt_d;
   logic [7:0]  err_cnt_q, err_cnt_d;

   always_comb begin
      job_cnt_d = job_cnt_q;
      err_cnt_d = err_cnt_q;
      if (qr_o && rsp_ack_i) begin
         if (job_cnt_q != 16'hFFFF) job_cnt_d = job_cnt_q + 16'd1;
         if (err_q && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         job_cnt_q <= '0;
         err_cnt_q <= '0;
      end else begin
         job_cnt_q <= job_cnt_d;
         err_cnt_q <= err_cnt_d;
      end
   end

   assign job_cnt_o = job_cnt_q;
   assign err_cnt_o = err_cnt_q;
`endif

endmodule

// File: tb/tb_min_max_job_scheduler.sv
// Randomised bench for min_max_job_scheduler with a behavioural engine and job-level model.
module tb_min_max_job_scheduler;
   localparam int unsigned TimeoutCyc = 64;

   logic         clk, rst;
   logic [1:0]   req;
   logic [127:0] arr0, arr1;
   logic [1:0]   gnt;
   logic         mem_we;
   logic [3:0]   mem_addr;
   logic [7:0]   mem_wdata;
   logic         eng_start, eng_done;
   logic [7:0]   eng_max, eng_min;
   logic         rsp_valid, rsp_id, rsp_err, rsp_ack;
   logic [7:0]   rsp_max, rsp_min;
   logic         qi, qc, qs, qw, qr;
`ifdef MINMAX_SCHED_STATS_EN
   logic [15:0]  job_cnt;
   logic [7:0]   err_cnt;
   int           m_jobs = 0, m_errs = 0;
`endif

   min_max_job_scheduler #(.TIMEOUT_CYC(TimeoutCyc), .TO_W(7)) dut (
      .clk_i(clk), .rst_i(rst), .req_i(req), .arr0_i(arr0), .arr1_i(arr1), .gnt_o(gnt),
      .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
      .eng_start_o(eng_start), .eng_done_i(eng_done), .eng_max_i(eng_max), .eng_min_i(eng_min),
      .rsp_valid_o(rsp_valid), .rsp_id_o(rsp_id), .rsp_max_o(rsp_max), .rsp_min_o(rsp_min),
      .rsp_err_o(rsp_err), .rsp_ack_i(rsp_ack),
      .qi_o(qi), .qc_o(qc), .qs_o(qs), .qw_o(qw), .qr_o(qr)
`ifdef MINMAX_SCHED_STATS_EN
      , .job_cnt_o(job_cnt), .err_cnt_o(err_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0, n_bad = 0;
   int last = 1;  // model: requester served last (1 => requester 0 first after reset)

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [15:0] max_min(input logic [127:0] a);
      logic [7:0] mx, mn;
      mx = 8'h00;
      mn = 8'hFF;
      for (int i = 0; i < 16; i++) begin
         if (a[8*i +: 8] > mx) mx = a[8*i +: 8];
         if (a[8*i +: 8] < mn) mn = a[8*i +: 8];
      end
      return {mx, mn};
   endfunction

   // Engine model. Mode 0: normal, 1: stale DONE lingers 2 cycles, 2: never finishes.
   int           emode = 0, elat = 0;
   int           ecnt, eph;
   logic [127:0] emem;
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         eng_done <= 1'b0;
         eng_max  <= 8'h00;
         eng_min  <= 8'h00;
         eph      <= 0;
         ecnt     <= 0;
      end else begin
         if (mem_we) emem[{mem_addr, 3'b000} +: 8] <= mem_wdata;
         if (eng_start) begin
            if (emode == 0) begin
               eng_done <= 1'b0;
               ecnt     <= elat;
               eph      <= 1;
            end else if (emode == 1) begin
               ecnt <= 1;
               eph  <= 2;
            end else begin
               eng_done <= 1'b0;
               eph      <= 0;
            end
         end else if (eph == 2) begin
            if (ecnt == 0) begin
               eng_done <= 1'b0;
               ecnt     <= elat;
               eph      <= 1;
            end else ecnt <= ecnt - 1;
         end else if (eph == 1) begin
            if (ecnt == 0) begin
               eng_done           <= 1'b1;
               {eng_max, eng_min} <= max_min(emem);
               eph                <= 0;
            end else ecnt <= ecnt - 1;
         end
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         check_eq("we_outside_copy", {31'd0, mem_we & ~qc}, 0);
         check_eq("start_outside_start", {31'd0, eng_start & ~qs}, 0);
         check_eq("state_onehot", $countones({qi, qc, qs, qw, qr}), 1);
      end
   end

   // One complete job: grant, 16-byte copy, start, wait, response, ack.
   task automatic do_job(input int mode, input int lat, input bit hold_req,
                         input logic [1:0] raise_mask);
      logic [1:0]   eg;
      logic [127:0] a;
      logic [15:0]  mm;
      int           k, w, exp_w, hold;
      bit           got;
      emode = mode;
      elat  = lat;
      eg    = (req == 2'b11) ? ((last == 1) ? 2'b01 : 2'b10) : req;
      got   = 1'b0;
      for (int c = 0; c < 8 && !got; c++) begin
         @(negedge clk);
         if (gnt != 2'b00) got = 1'b1;
      end
      check_eq("gnt", {30'd0, gnt}, {30'd0, eg});
      if (!got) return;
      k = eg[1] ? 1 : 0;
      a = k ? arr1 : arr0;
      if (!hold_req) req[k] = 1'b0;
      if (raise_mask[1] && !req[1]) begin
         arr1   = {$urandom, $urandom, $urandom, $urandom};
         req[1] = 1'b1;
      end
      for (int i = 0; i < 16; i++) begin
         if (i > 0) @(negedge clk);
         check_eq("copy_we", {31'd0, mem_we}, 1);
         check_eq("copy_addr", {28'd0, mem_addr}, i);
         check_eq("copy_data", {24'd0, mem_wdata}, {24'd0, a[8*i +: 8]});
         check_eq("gnt_pulse", {30'd0, gnt}, (i == 0) ? {30'd0, eg} : 0);
      end
      @(negedge clk);
      check_eq("eng_start", {31'd0, eng_start}, 1);
      w = 0;
      for (int c = 0; c < 200; c++) begin
         @(negedge clk);
         if (rsp_valid) break;
         w++;
         rsp_ack = 1'($urandom_range(0, 1));  // acks outside RESP must be ignored
      end
      rsp_ack = 1'b0;
      exp_w = (mode == 0) ? lat + 2 : (mode == 1) ? lat + 4 : TimeoutCyc;
      check_eq("wait_cycles", w, exp_w);
      mm   = max_min(a);
      hold = $urandom_range(0, 3);
      for (int h = 0; h <= hold; h++) begin
         if (h > 0) @(negedge clk);
         check_eq("rsp_valid", {31'd0, rsp_valid}, 1);
         check_eq("rsp_id", {31'd0, rsp_id}, k);
         check_eq("rsp_err", {31'd0, rsp_err}, (mode == 2) ? 1 : 0);
         check_eq("rsp_max", {24'd0, rsp_max}, (mode == 2) ? 0 : {24'd0, mm[15:8]});
         check_eq("rsp_min", {24'd0, rsp_min}, (mode == 2) ? 0 : {24'd0, mm[7:0]});
      end
      rsp_ack = 1'b1;
      @(negedge clk);
      rsp_ack = 1'b0;
      check_eq("idle_after_ack", {30'd0, qi, rsp_valid}, 2);
      last = k;
`ifdef MINMAX_SCHED_STATS_EN
      m_jobs++;
      if (mode == 2) m_errs++;
      check_eq("job_cnt", {16'd0, job_cnt}, m_jobs);
      check_eq("err_cnt", {24'd0, err_cnt}, m_errs);
`endif
   endtask

   initial begin
      rst     = 1'b1;
      req     = 2'b00;
      rsp_ack = 1'b0;
      arr0    = '0;
      arr1    = '0;
      #12;
      check_eq("reset_state", {27'd0, qi, qc, qs, qw, qr}, 5'b10000);
      check_eq("reset_outputs", {22'd0, gnt, mem_we, eng_start, rsp_valid, rsp_err, rsp_max[3:0]},
               0);
      @(negedge clk);
      rst = 1'b0;

      // Simultaneous requests after reset
      arr0 = 128'hF5_84_02_02_99_02_85_F4_F4_23_83_90_F4_64_9A_3B;
      arr1 = 128'h01_B9_39_53_09_09_73_91_A9_A9_29_31_31_31_56_93;
      req  = 2'b11;
      do_job(0, 3, 1'b0, 2'b00);
      do_job(0, 5, 1'b0, 2'b00);

      // Ascending byte copy
      for (int i = 0; i < 16; i++) arr0[8*i +: 8] = 8'h73 + 8'(i);
      req = 2'b01;
      do_job(0, 0, 1'b0, 2'b00);

      // Stale DONE, timeout, and DONE coinciding with the last timeout cycle
      arr1 = {$urandom, $urandom, $urandom, $urandom};
      req  = 2'b10;
      do_job(1, 2, 1'b0, 2'b00);
      arr0 = {$urandom, $urandom, $urandom, $urandom};
      req  = 2'b01;
      do_job(2, 0, 1'b0, 2'b00);
      arr0 = {$urandom, $urandom, $urandom, $urandom};
      req  = 2'b01;
      do_job(0, TimeoutCyc - 2, 1'b0, 2'b00);

      // Fairness: req0 held, req1 rises during job 0
      arr0 = {$urandom, $urandom, $urandom, $urandom};
      req  = 2'b01;
      do_job(0, 1, 1'b1, 2'b10);
      do_job(0, 1, 1'b0, 2'b00);
      do_job(0, 1, 1'b0, 2'b00);

      // Reset in the middle of COPY
      arr1 = {$urandom, $urandom, $urandom, $urandom};
      req  = 2'b10;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (mem_we && mem_addr == 4'd7) break;
      end
      check_eq("mid_copy_addr", {28'd0, mem_addr}, 7);
      #1 rst = 1'b1;
      #1;
      check_eq("rst_async_we", {31'd0, mem_we}, 0);
      check_eq("rst_async_qi", {31'd0, qi}, 1);
      @(negedge clk);
      rst  = 1'b0;
      last = 1;
      arr0 = {$urandom, $urandom, $urandom, $urandom};
      req  = 2'b11;
      do_job(0, 2, 1'b0, 2'b00);
      do_job(0, 2, 1'b0, 2'b00);

      // Random traffic
      for (int j = 0; j < 40; j++) begin
         int r, md;
         for (int k = 0; k < 2; k++) begin
            if (!req[k] && $urandom_range(0, 1) == 1) begin
               if (k == 0) arr0 = {$urandom, $urandom, $urandom, $urandom};
               else        arr1 = {$urandom, $urandom, $urandom, $urandom};
               req[k] = 1'b1;
            end
         end
         if (req == 2'b00) begin
            arr0   = {$urandom, $urandom, $urandom, $urandom};
            req[0] = 1'b1;
         end
         r  = $urandom_range(0, 9);
         md = (r == 0) ? 2 : (r < 3) ? 1 : 0;
         do_job(md, $urandom_range(0, 11), 1'b0, 2'b00);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end
endmodule
